gf_serial_mul: RTL

Bit-serial multiplier over GF(2^WIDTH), reducing modulo x^WIDTH + POLY. It is the parametrised successor of the fixed multiply-by-2 (xtime) primitive. Each cycle it applies one xtime step plus a conditional XOR, so a full product costs WIDTH cycles. It serves the AES MixColumns/InvMixColumns datapath (multipliers such as 0x09, 0x0B, 0x0D and 0x0E) and other GF arithmetic needs, with a valid/ready handshake on both sides.

---
 rtl/gf_serial_mul.sv | 91 +++++++++
 1 files changed

// File: rtl/gf_serial_mul.sv
// Bit-serial GF(2^WIDTH) multiplier: one xtime step plus conditional XOR per cycle, MSB of inB first.
// Optional GF_MUL_ZERO_FAST_EN: a zero operand finishes after a single step instead of WIDTH steps.
module gf_serial_mul #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1B)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outResult
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_xt;
  logic [WIDTH-1:0] w_accNext;

`ifdef GF_MUL_ZERO_FAST_EN
  logic w_zeroOp;
  assign w_zeroOp = (inA == '0) || (inB == '0);
`endif

  assign w_xt      = {r_acc[WIDTH-2:0], 1'b0} ^ (r_acc[WIDTH-1] ? POLY : '0);
  assign w_accNext = w_xt ^ (r_b[r_count] ? r_a : '0);

  assign inReady   = (r_state == IDLE);
  assign outValid  = (r_state == DONE);
  assign outResult = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (inValid) w_nextState = BUSY;
      BUSY:    if (r_count == '0) w_nextState = DONE;
      DONE:    if (outReady) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // With a zero operand the accumulator can only ever hold zero, so the
  // fast path just runs one final step from count 0 to reach DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (inValid) begin
            r_a     <= inA;
            r_b     <= inB;
            r_acc   <= '0;
            r_count <= CW'(WIDTH - 1);
`ifdef GF_MUL_ZERO_FAST_EN
            if (w_zeroOp) r_count <= '0;
`endif
          end
        end
        BUSY: begin
          r_acc <= w_accNext;
          if (r_count == '0) r_result <= w_accNext;
          else               r_count  <= r_count - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
